// File: rtl/hazard_scoreboard_if.sv
// ID-stage request/response bundle between the decode controller and the hazard scoreboard.
// id_valid qualifies every id_* field; the scoreboard answers combinationally in the same cycle.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int STAT_W     = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_reg_write;
  logic [1:0]            id_class;
  logic                  id_branch;
  logic                  id_branch_taken;
  logic [1:0]            id_jump;

  logic                  pc_write;
  logic                  if_id_write_en;
  logic                  if_id_flush;
  logic                  cancel_id_ex;
  logic [1:0]            pc_sel;
  logic                  stall;
  logic [STAT_W-1:0]     stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_reg_write,
           id_class, id_branch, id_branch_taken, id_jump,
    input  pc_write, if_id_write_en, if_id_flush, cancel_id_ex, pc_sel, stall, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_reg_write,
           id_class, id_branch, id_branch_taken, id_jump,
    output pc_write, if_id_write_en, if_id_flush, cancel_id_ex, pc_sel, stall, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-result scoreboard for the ID stage: RAW/WAW/MUL-structural/branch
// dependency stalls, control-transfer PC select and flush, and a saturating stall counter.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 3,
  parameter int STAT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam logic [1:0] C_ALU = 2'b00, C_LOAD = 2'b01, C_MUL = 2'b10;

  logic [CNT_W-1:0]      r_pend [NUM_REGS];
  logic [CNT_W-1:0]      r_mul_cnt;
  logic [REG_ADDR_W-1:0] r_last_dest;
  logic                  r_last_wr;
  logic [STAT_W-1:0]     r_stall_cycles;

  logic [CNT_W-1:0] w_new_lat;
  logic w_raw, w_waw, w_struct, w_brdep, w_stall, w_issue, w_dest_wr;

  always_comb begin
    w_new_lat = '0;
    case (bus.id_class)
      C_ALU:   w_new_lat = '0;
      C_LOAD:  w_new_lat = CNT_W'(LOAD_LAT);
      C_MUL:   w_new_lat = CNT_W'(MUL_LAT - 1);
      default: w_new_lat = '0;
    endcase
  end

  assign w_raw    = (bus.id_use_rs && bus.id_rs != '0 && r_pend[bus.id_rs] != '0) ||
                    (bus.id_use_rt && bus.id_rt != '0 && r_pend[bus.id_rt] != '0);
  assign w_waw    = bus.id_reg_write && bus.id_dest != '0 && r_pend[bus.id_dest] > w_new_lat;
  assign w_struct = bus.id_class == C_MUL && r_mul_cnt != '0;
  // Branches and jr compare in ID, so even a zero-latency ALU result is one cycle too late.
  assign w_brdep  = (bus.id_branch || bus.id_jump == 2'b11) && r_last_wr && r_last_dest != '0 &&
                    ((bus.id_use_rs && bus.id_rs == r_last_dest) ||
                     (bus.id_use_rt && bus.id_rt == r_last_dest));
  assign w_stall   = bus.id_valid && (w_raw || w_waw || w_struct || w_brdep);
  assign w_issue   = bus.id_valid && !w_stall;
  assign w_dest_wr = w_issue && bus.id_reg_write && bus.id_dest != '0;

  always_comb begin
    bus.pc_write       = 1'b1;
    bus.if_id_write_en = 1'b1;
    bus.if_id_flush    = 1'b0;
    bus.cancel_id_ex   = 1'b0;
    bus.pc_sel         = 2'b00;
    if (w_stall) begin
      bus.pc_write       = 1'b0;
      bus.if_id_write_en = 1'b0;
      bus.cancel_id_ex   = 1'b1;
    end else if (w_issue) begin
      if (bus.id_jump == 2'b10) begin
        bus.pc_sel      = 2'b10;
        bus.if_id_flush = 1'b1;
      end else if (bus.id_jump == 2'b11) begin
        bus.pc_sel      = 2'b11;
        bus.if_id_flush = 1'b1;
      end else if (bus.id_branch && bus.id_branch_taken) begin
        bus.pc_sel      = 2'b01;
        bus.if_id_flush = 1'b1;
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.stall_cycles = r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_pend[r] <= '0;
      r_mul_cnt      <= '0;
      r_last_dest    <= '0;
      r_last_wr      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_pend[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_dest_wr && bus.id_dest == REG_ADDR_W'(r))
          r_pend[r] <= w_new_lat;
        else if (r_pend[r] != '0)
          r_pend[r] <= r_pend[r] - 1'b1;
      end
      if (w_issue && bus.id_class == C_MUL)
        r_mul_cnt <= CNT_W'(MUL_LAT - 1);
      else if (r_mul_cnt != '0)
        r_mul_cnt <= r_mul_cnt - 1'b1;
      r_last_wr <= w_dest_wr;
      if (w_dest_wr) r_last_dest <= bus.id_dest;
      if (w_stall && r_stall_cycles != '1)
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each step drives one ID instruction, queues the
// expected control outputs and checks them mid-cycle; a small MUL model covers saturation.
module tb_hazard_scoreboard;
  localparam int STAT_W = 8;
  localparam logic [1:0] C_ALU = 2'b00, C_LOAD = 2'b01, C_MUL = 2'b10, C_NONE = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_ADDR_W(5), .STAT_W(STAT_W)) bus ();
  hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(1), .MUL_LAT(4), .CNT_W(3), .STAT_W(STAT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [6:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int m_cnt;
  int exp_stat;

  // {stall, pc_write, if_id_write_en, cancel_id_ex, if_id_flush, pc_sel}
  function automatic logic [6:0] exp_vec(input logic s, input logic [1:0] sel, input logic f);
    return {s, ~s, ~s, s, f, sel};
  endfunction

  task automatic set_idle();
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 1'b0;
    bus.id_use_rt = 1'b0; bus.id_dest = '0; bus.id_reg_write = 1'b0; bus.id_class = C_NONE;
    bus.id_branch = 1'b0; bus.id_branch_taken = 1'b0; bus.id_jump = 2'b00;
  endtask

  task automatic step(input string tag, input logic v, input logic [1:0] cls,
                      input logic [4:0] dest, input logic wr,
                      input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                      input logic br, input logic tk, input logic [1:0] jmp,
                      input logic e_stall, input logic [1:0] e_sel, input logic e_flush);
    logic [6:0] obs, exp;
    @(posedge clk);
    #1;
    bus.id_valid = v; bus.id_class = cls; bus.id_dest = dest; bus.id_reg_write = wr;
    bus.id_rs = rs; bus.id_use_rs = urs; bus.id_rt = rt; bus.id_use_rt = urt;
    bus.id_branch = br; bus.id_branch_taken = tk; bus.id_jump = jmp;
    exp_q.push_back(exp_vec(e_stall, e_sel, e_flush));
    @(negedge clk);
    obs = {bus.stall, bus.pc_write, bus.if_id_write_en, bus.cancel_id_ex, bus.if_id_flush, bus.pc_sel};
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: outputs=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_step(input string tag);
    step(tag, 1'b0, C_NONE, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic check_stat(input string tag, input int exp);
    checks++;
    assert (bus.stall_cycles === STAT_W'(exp)) else begin
      failures++;
      $error("FAIL %s: stall_cycles=%0d expected=%0d", tag, bus.stall_cycles, exp);
    end
  endtask

  initial begin
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    assert ({bus.stall, bus.pc_write, bus.if_id_write_en, bus.cancel_id_ex, bus.if_id_flush, bus.pc_sel}
            === 7'b0110000) else begin
      failures++;
      $error("FAIL reset_outputs: got=%b expected=0110000",
             {bus.stall, bus.pc_write, bus.if_id_write_en, bus.cancel_id_ex, bus.if_id_flush, bus.pc_sel});
    end
    check_stat("reset_stat", 0);

    // ALU -> dependent ALU: forwarding covers it
    step("alu_r3",     1, C_ALU, 5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 0, 2'b00, 0, 2'b00, 0);
    step("alu_use_r3", 1, C_ALU, 5'd6, 1, 5'd3, 1, 5'd3, 1, 0, 0, 2'b00, 0, 2'b00, 0);
    check_stat("alu_stat", 0);
    idle_step("idle0");

    // Load-use: one bubble
    step("load_r5",    1, C_LOAD, 5'd5, 1, 5'd1, 1, 5'd0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    step("use_r5_stl", 1, C_ALU,  5'd9, 1, 5'd5, 1, 5'd2, 1, 0, 0, 2'b00, 1, 2'b00, 0);
    step("use_r5_iss", 1, C_ALU,  5'd9, 1, 5'd5, 1, 5'd2, 1, 0, 0, 2'b00, 0, 2'b00, 0);
    check_stat("load_stat", 1);

    // MUL structural hazard, then r7 already retired
    step("mul_r7", 1, C_MUL, 5'd7, 1, 5'd1, 1, 5'd2, 1, 0, 0, 2'b00, 0, 2'b00, 0);
    for (int i = 0; i < 3; i++)
      step("mul_r8_stl", 1, C_MUL, 5'd8, 1, 5'd1, 1, 5'd2, 1, 0, 0, 2'b00, 1, 2'b00, 0);
    step("mul_r8_iss", 1, C_MUL, 5'd8, 1, 5'd1, 1, 5'd2, 1, 0, 0, 2'b00, 0, 2'b00, 0);
    check_stat("mul_stat", 4);
    step("use_r7",     1, C_ALU, 5'd10, 1, 5'd7, 1, 5'd0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    repeat (3) idle_step("drain");

    // WAW: ALU r2 may not overtake MUL r2
    step("mul_r2", 1, C_MUL, 5'd2, 1, 5'd1, 1, 5'd0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    for (int i = 0; i < 3; i++)
      step("waw_stl", 1, C_ALU, 5'd2, 1, 5'd1, 1, 5'd0, 0, 0, 0, 2'b00, 1, 2'b00, 0);
    step("waw_iss", 1, C_ALU, 5'd2, 1, 5'd1, 1, 5'd0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    check_stat("waw_stat", 7);

    // Branch dependency, taken branch, jumps
    step("alu_r4",     1, C_ALU,  5'd4, 1, 5'd1, 1, 5'd1, 1, 0, 0, 2'b00, 0, 2'b00, 0);
    step("beq_r4_stl", 1, C_NONE, 5'd0, 0, 5'd4, 1, 5'd0, 1, 1, 1, 2'b00, 1, 2'b00, 0);
    step("beq_r4_tkn", 1, C_NONE, 5'd0, 0, 5'd4, 1, 5'd0, 1, 1, 1, 2'b00, 0, 2'b01, 1);
    idle_step("after_beq");
    check_stat("br_stat", 8);
    step("j",          1, C_NONE, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 2'b10, 0, 2'b10, 1);
    step("alu_r11",    1, C_ALU,  5'd11, 1, 5'd1, 1, 5'd1, 1, 0, 0, 2'b00, 0, 2'b00, 0);
    step("jr_r11_stl", 1, C_NONE, 5'd0, 0, 5'd11, 1, 5'd0, 0, 0, 0, 2'b11, 1, 2'b00, 0);
    step("jr_r11",     1, C_NONE, 5'd0, 0, 5'd11, 1, 5'd0, 0, 0, 0, 2'b11, 0, 2'b11, 1);
    step("beq_ntkn",   1, C_NONE, 5'd0, 0, 5'd1, 1, 5'd2, 1, 1, 0, 2'b00, 0, 2'b00, 0);

    // Writes to r0 never create a hazard
    step("load_r0",    1, C_LOAD, 5'd0, 1, 5'd1, 1, 5'd0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    step("beq_r0",     1, C_NONE, 5'd0, 0, 5'd0, 1, 5'd0, 1, 1, 1, 2'b00, 0, 2'b01, 1);
    check_stat("r0_stat", 9);

    // Saturation: continuous MUL stream stalls 3 of every 4 cycles
    m_cnt = 0;
    exp_stat = 9;
    for (int i = 0; i < 400; i++) begin
      step("mul_stream", 1, C_MUL, 5'd12, 1, 5'd1, 1, 5'd2, 1, 0, 0, 2'b00,
           (m_cnt != 0), 2'b00, 0);
      if (m_cnt != 0) begin
        m_cnt--;
        if (exp_stat < (2**STAT_W) - 1) exp_stat++;
      end else begin
        m_cnt = 3;
      end
    end
    idle_step("sat_idle");
    check_stat("sat_stat", exp_stat);
    check_stat("sat_all_ones", (2**STAT_W) - 1);

    // Reset with results in flight: everything forgotten
    step("mul_r12_pre", 1, C_MUL, 5'd12, 1, 5'd1, 1, 5'd2, 1, 0, 0, 2'b00, 0, 2'b00, 0);
    @(posedge clk);
    #1;
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_stat("rst_stat", 0);
    step("post_rst_mul", 1, C_MUL, 5'd13, 1, 5'd12, 1, 5'd0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    check_stat("post_rst_stat", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
